fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 111 +++++++++++
 tb/tb_fft_frame_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: aligns a sample stream into DEPTH-sample FFT frames with flush and resync control
module fft_frame_ctrl #(
  parameter int DATA_W   = 20,
  parameter int DEPTH    = 128,
  parameter int INIT_CYC = 4
) (
  input  logic              mclk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_abort,
  input  logic              s_vld,
  input  logic              s_sof,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_rdy,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data,
  output logic              o_init,
  output logic              o_busy,
  output logic              o_err_align,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_drop_cnt
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(INIT_CYC) + 1;
  typedef enum logic [1:0] {IDLE, SYNC, RUN, INIT} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc, sof_ok, flush_done, fwd, drop, err;
  logic              vld_q, init_q, busy_q, err_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       frame_q, drop_q;
  assign s_rdy       = (state_q == SYNC) || (state_q == RUN);
  assign acc         = s_vld & s_rdy;
  assign sof_ok      = s_sof == (idx_q == '0);
  assign flush_done  = cnt_q == CW'(INIT_CYC - 1);
  assign o_vld       = vld_q;
  assign o_data      = data_q;
  assign o_init      = init_q;
  assign o_busy      = busy_q;
  assign o_err_align = err_q;
  assign o_frame_cnt = frame_q;
  assign o_drop_cnt  = drop_q;
  // next-state logic; the flush counter restarts from zero whenever INIT is (re)entered or aborted
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    fwd     = 1'b0;
    drop    = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: state_d = i_enable ? INIT : IDLE;
      INIT: begin
        idx_d = '0;
        if (i_abort) cnt_d = '0;
        else if (flush_done) state_d = i_enable ? SYNC : IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      SYNC: begin
        if (i_abort) state_d = INIT;
        else if (acc && s_sof) begin
          fwd     = 1'b1;
          idx_d   = IW'(1);
          state_d = RUN;
        end
        else if (acc) drop = 1'b1;
        else if (!i_enable) state_d = IDLE;
      end
      RUN: begin
        if (i_abort) state_d = INIT;
        else if (acc && sof_ok) begin
          fwd   = 1'b1;
          idx_d = idx_q + 1'b1;
        end
        else if (acc) begin
          err     = 1'b1;
          state_d = INIT;
        end
        else if (idx_q == '0 && !i_enable) state_d = INIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counters and registered outputs; frame count steps with the o_vld of the last sample
  always_ff @(posedge mclk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vld_q   <= fwd;
      data_q  <= fwd ? s_data : data_q;
      init_q  <= state_d == INIT;
      busy_q  <= state_d != IDLE;
      err_q   <= err;
      frame_q <= (fwd && &idx_q) ? frame_q + 16'd1 : frame_q;
      drop_q  <= (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed stimulus against a frame-level behavioural model plus literal checks
module tb_fft_frame_ctrl;
  localparam int DW = 20;
  localparam int D  = 8;
  localparam int IC = 4;
  logic          mclk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_abort = 1'b0;
  logic          s_vld = 1'b0;
  logic          s_sof = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_rdy, o_vld, o_init, o_busy, o_err_align;
  logic [DW-1:0] o_data;
  logic [15:0]   o_frame_cnt, o_drop_cnt;
  fft_frame_ctrl #(.DATA_W(DW), .DEPTH(D), .INIT_CYC(IC)) dut (
    .mclk(mclk), .i_rst(i_rst), .i_enable(i_enable), .i_abort(i_abort),
    .s_vld(s_vld), .s_sof(s_sof), .s_data(s_data), .s_rdy(s_rdy),
    .o_vld(o_vld), .o_data(o_data), .o_init(o_init), .o_busy(o_busy),
    .o_err_align(o_err_align), .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt)
  );
  always #5 mclk = ~mclk;
  int checks = 0;
  int errors = 0;
  // model: powered flag, remaining flush cycles, next frame position (-1 = hunting for sof)
  bit            m_on = 1'b0;
  int            m_flush = 0;
  int            m_pos = -1;
  bit            m_acc;
  logic          e_vld = 1'b0, e_init = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  logic [DW-1:0] e_data = '0;
  logic [15:0]   e_frames = '0, e_drops = '0;
  int cyc = 0, init_hi = 0, err_n = 0, vld_n = 0;
  int seen[$];
  int vld_cyc[$];
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic chk1(input string n, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, got, exp);
    end
  endtask
  task automatic tick(input logic v, input logic sof, input int d, input logic ab = 1'b0);
    s_vld   = v;
    s_sof   = sof;
    s_data  = DW'(d);
    i_abort = ab;
    @(posedge mclk);
    @(negedge mclk);
    #1;
  endtask
  initial forever begin
    @(posedge mclk or posedge i_rst);
    if (i_rst) begin
      m_on = 0; m_flush = 0; m_pos = -1;
      e_vld = 0; e_data = '0; e_init = 0; e_busy = 0; e_err = 0;
      e_frames = '0; e_drops = '0;
    end else begin
      m_acc = s_vld && m_on && m_flush == 0;
      e_vld = 0;
      e_err = 0;
      if (!m_on) begin
        if (i_enable) begin m_on = 1; m_flush = IC; end
      end
      else if (m_flush > 0) begin
        if (i_abort) m_flush = IC;
        else begin
          m_flush--;
          if (m_flush == 0) begin m_pos = -1; m_on = i_enable; end
        end
      end
      else if (i_abort) m_flush = IC;
      else if (m_pos < 0) begin
        if (m_acc && s_sof) begin e_vld = 1; e_data = s_data; m_pos = 1; end
        else if (m_acc) begin if (e_drops != 16'hFFFF) e_drops++; end
        else if (!i_enable) m_on = 0;
      end
      else if (m_acc && s_sof == (m_pos == 0)) begin
        e_vld = 1;
        e_data = s_data;
        if (m_pos == D - 1) e_frames++;
        m_pos = (m_pos + 1) % D;
      end
      else if (m_acc) begin e_err = 1; m_flush = IC; end
      else if (m_pos == 0 && !i_enable) m_flush = IC;
      e_init = m_flush > 0;
      e_busy = m_on;
    end
  end
  initial forever begin
    @(negedge mclk);
    cyc++;
    if (o_init) init_hi++;
    if (o_err_align) err_n++;
    if (o_vld) begin
      vld_n++;
      seen.push_back(int'(o_data));
      vld_cyc.push_back(cyc);
    end
    chk1("vld", o_vld, e_vld);
    chk("data", int'(o_data), int'(e_data));
    chk1("init", o_init, e_init);
    chk1("busy", o_busy, e_busy);
    chk1("err_align", o_err_align, e_err);
    chk("frame_cnt", int'(o_frame_cnt), int'(e_frames));
    chk("drop_cnt", int'(o_drop_cnt), int'(e_drops));
    chk1("rdy", s_rdy, m_on && m_flush == 0);
    chk1("vld_with_init", o_vld & o_init, 1'b0);
  end
  initial begin
    repeat (2) tick(0, 0, 0);
    chk1("rst_vld", o_vld, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk("rst_frames", int'(o_frame_cnt), 0);
    i_rst = 1'b0;
    tick(0, 0, 0, 1'b1);
    chk1("idle_wait_busy", o_busy, 1'b0);
    i_enable = 1'b1;
    repeat (5) tick(0, 0, 0);
    chk("start_init_len", init_hi, 4);
    chk1("sync_rdy", s_rdy, 1'b1);
    for (int i = 0; i < 16; i++) tick(1'b1, i % D == 0, i + 1);
    tick(0, 0, 0);
    chk("two_frames_vld", vld_n, 16);
    for (int i = 0; i < 16; i++) chk("two_frames_data", seen[i], i + 1);
    chk("two_frames_no_bubble", vld_cyc[15] - vld_cyc[0], 15);
    chk("two_frames_cnt", int'(o_frame_cnt), 2);
    tick(0, 0, 0, 1'b1);
    repeat (4) tick(0, 0, 0);
    chk("abort_init_len", init_hi, 8);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 100 + i);
    for (int i = 0; i < 8; i++) tick(1'b1, i == 0, 201 + i);
    tick(0, 0, 0);
    chk("sync_drops", int'(o_drop_cnt), 3);
    chk("sync_vld", vld_n, 24);
    chk("sync_first", seen[16], 201);
    chk("sync_frames", int'(o_frame_cnt), 3);
    for (int i = 0; i < 4; i++) tick(1'b1, i == 0, 301 + i);
    tick(1'b1, 1'b1, 305);
    repeat (4) tick(0, 0, 0);
    chk("misalign_pulses", err_n, 1);
    chk("misalign_vld", vld_n, 28);
    chk("misalign_last", seen[27], 304);
    chk("misalign_frames", int'(o_frame_cnt), 3);
    chk("misalign_init_len", init_hi, 12);
    chk1("misalign_resync", s_rdy, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, i == 0, 401 + i);
    tick(1'b1, 1'b0, 404, 1'b1);
    repeat (4) tick(0, 0, 0);
    chk("abort_vld", vld_n, 31);
    chk("abort_last", seen[30], 403);
    chk("abort_drops", int'(o_drop_cnt), 3);
    chk("abort2_init_len", init_hi, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) i_enable = 1'b0;
      tick(1'b1, i == 0, 501 + i);
    end
    tick(0, 0, 0);
    repeat (4) tick(0, 0, 0);
    chk("stop_vld", vld_n, 39);
    chk("stop_last", seen[38], 508);
    chk("stop_frames", int'(o_frame_cnt), 4);
    chk("stop_init_len", init_hi, 20);
    chk1("stop_busy", o_busy, 1'b0);
    chk1("stop_rdy", s_rdy, 1'b0);
    i_enable = 1'b1;
    repeat (5) tick(0, 0, 0);
    for (int i = 0; i < 6; i++) tick(1'b1, i == 0, 601 + i);
    chk("pre_rst_vld", vld_n, 45);
    s_vld  = 1'b1;
    s_sof  = 1'b0;
    s_data = DW'(607);
    #1 i_rst = 1'b1;
    #1;
    chk1("arst_vld", o_vld, 1'b0);
    chk("arst_data", int'(o_data), 0);
    chk1("arst_busy", o_busy, 1'b0);
    chk1("arst_init", o_init, 1'b0);
    chk1("arst_err", o_err_align, 1'b0);
    chk("arst_frames", int'(o_frame_cnt), 0);
    chk("arst_drops", int'(o_drop_cnt), 0);
    chk1("arst_rdy", s_rdy, 1'b0);
    repeat (2) tick(0, 0, 0);
    i_rst = 1'b0;
    i_enable = 1'b0;
    repeat (3) tick(0, 0, 0);
    chk("post_rst_no_vld", vld_n, 45);
    chk1("post_rst_busy", o_busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
